// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder family: FSM state encoding
// and WIDTH/DIGIT configuration helpers.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Guarded so an illegal DIGIT never reaches the modulo.
    function automatic bit cfg_legal(input int width, input int digit);
        if (digit < 1)
            return 1'b0;
        if (width < digit)
            return 1'b0;
        return (width % digit) == 0;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational digit slice: a ripple chain of DIGIT full adders that also
// exposes the carry into its MSB so the caller can detect signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle digit-serial adder: {cout,sum} = a + b + cin, DIGIT bits per
// clock, with a start/done handshake and signed-overflow detection.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N     = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (!cfg_legal(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]   dig_a, dig_b, dig_s;
    logic               dig_co, dig_cmsb;

    // Operands stay in place; the counter selects which digit feeds the slice.
    assign dig_a = a_q[cnt_q*DIGIT +: DIGIT];
    assign dig_b = b_q[cnt_q*DIGIT +: DIGIT];

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (dig_a),
        .b     (dig_b),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    always_comb begin
        // NOTE: every target gets a hold value first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[cnt_q*DIGIT +: DIGIT] = dig_s;
                carry_d = dig_co;
                if (cnt_q == LAST) begin
                    cout_d  = dig_co;
                    ovf_d   = dig_co ^ dig_cmsb;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand, carry and counter are datapath-only but are cleared anyway
            // so an aborted operation leaves no stale state behind.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (DIGIT=4, 16, 1) share one
// stimulus stream and are each compared every cycle to an arithmetic model.
module tb_serial_adder;

    localparam int W    = 16;
    localparam int NDUT = 3;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a, b;
    logic          cin;

    logic          rdy [NDUT];
    logic          bsy [NDUT];
    logic          dn  [NDUT];
    logic [W-1:0]  sm  [NDUT];
    logic          co  [NDUT];
    logic          ov  [NDUT];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .sum(sm[0]), .cout(co[0]), .overflow(ov[0])
    );
    serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .sum(sm[1]), .cout(co[1]), .overflow(ov[1])
    );
    serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .sum(sm[2]), .cout(co[2]), .overflow(ov[2])
    );

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d (lat %0d) at %0t: got %h expected %h", name, k, lat_of(k), $time, act, exp);
        end
    endtask

    // Model: phase 0 = idle, 1..lat = busy cycles, lat+1 = done cycle.
    int          ph    [NDUT];
    logic [W:0]  pend  [NDUT];
    logic        pend_o[NDUT];
    logic [W:0]  res   [NDUT];
    logic        res_o [NDUT];

    function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) begin
                ph[k]    <= 0;
                res[k]   <= '0;
                res_o[k] <= 1'b0;
                pend[k]  <= '0;
                pend_o[k] <= 1'b0;
            end else if (ph[k] == 0) begin
                if (start) begin
                    ph[k]     <= 1;
                    pend[k]   <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    pend_o[k] <= signed_ovf(a, b, cin);
                end
            end else if (ph[k] == lat_of(k)) begin
                ph[k]    <= ph[k] + 1;
                res[k]   <= pend[k];
                res_o[k] <= pend_o[k];
            end else if (ph[k] == lat_of(k) + 1) begin
                ph[k] <= 0;
            end else begin
                ph[k] <= ph[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < NDUT; k++) begin
                check("ready", k, 32'(rdy[k]), 32'(ph[k] == 0));
                check("busy",  k, 32'(bsy[k]), 32'(ph[k] >= 1 && ph[k] <= lat_of(k)));
                check("done",  k, 32'(dn[k]),  32'(ph[k] == lat_of(k) + 1));
                if (!(ph[k] >= 1 && ph[k] <= lat_of(k))) begin
                    check("sum",      k, 32'(sm[k]), 32'(res[k][W-1:0]));
                    check("cout",     k, 32'(co[k]), 32'(res[k][W]));
                    check("overflow", k, 32'(ov[k]), 32'(res_o[k]));
                end
            end
        end
    end

    // One start pulse (optionally held for 'hold' extra cycles with junk
    // operands), then literal checks of each DUT's done latency and results.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input int hold,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        bit seen [NDUT];
        int nseen;
        for (int k = 0; k < NDUT; k++) seen[k] = 1'b0;
        nseen = 0;
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 40 && nseen < NDUT; c++) begin
            if (c <= hold) begin
                start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (dn[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    nseen++;
                    check("latency",      k, 32'(c),     32'(lat_of(k)));
                    check("lit_sum",      k, 32'(sm[k]), 32'(es));
                    check("lit_cout",     k, 32'(co[k]), 32'(ec));
                    check("lit_overflow", k, 32'(ov[k]), 32'(eo));
                end
            end
        end
        start = 1'b0;
        for (int k = 0; k < NDUT; k++)
            if (!seen[k]) check("done_timeout", k, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ready", k, 32'(rdy[k]), 32'd1);
            check("rst_busy",  k, 32'(bsy[k]), 32'd0);
            check("rst_done",  k, 32'(dn[k]),  32'd0);
            check("rst_sum",   k, 32'(sm[k]),  32'd0);
            check("rst_cout",  k, 32'(co[k]),  32'd0);
            check("rst_ovf",   k, 32'(ov[k]),  32'd0);
        end

        run_op(16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b1, 0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1);
        run_op(16'h0001, 16'h0001, 1'b0, 2, 16'h0002, 1'b0, 1'b0);

        // Abort mid-operation with an asynchronous reset between clock edges.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("abort_ready", k, 32'(rdy[k]), 32'd1);
            check("abort_busy",  k, 32'(bsy[k]), 32'd0);
            check("abort_done",  k, 32'(dn[k]),  32'd0);
            check("abort_sum",   k, 32'(sm[k]),  32'd0);
            check("abort_cout",  k, 32'(co[k]),  32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_op(16'h00FF, 16'h0F01, 1'b0, 0, 16'h1000, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            logic [W:0]   full;
            ra = W'($urandom); rb = W'($urandom); rc = 1'(($urandom) & 1);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, 0, full[W-1:0], full[W], signed_ovf(ra, rb, rc));
        end

        // Free-running random traffic: starts land in every state.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) == 0);
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (25) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
